// File: rtl/ram_tdp_pkg.sv
// Shared definitions for the byte-enabled true dual-port RAM.
package ram_tdp_pkg;

  // Upper bounds on the request payload; module parameters must fit inside.
  localparam int unsigned MAX_AWIDTH = 16;
  localparam int unsigned MAX_DWIDTH = 64;
  localparam int unsigned MAX_BYTES  = MAX_DWIDTH / 8;

  // Collision policy: which port owns a byte both ports write in one cycle.
  localparam int unsigned COLL_WIN_PORT = 0;

  // Cross-port read-during-write data selection.
  localparam int unsigned RDW_OLD_DATA = 0;
  localparam int unsigned RDW_NEW_DATA = 1;

  // Only one or two register stages are supported on the read path.
  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Number of byte lanes in a data word.
  function automatic int unsigned num_bytes(input int unsigned dw);
    return dw / 8;
  endfunction

  // Per-port request, sized for the largest supported configuration.
  typedef struct packed {
    logic                  cs;
    logic                  we;
    logic [MAX_BYTES-1:0]  be;
    logic [MAX_AWIDTH-1:0] addr;
    logic [MAX_DWIDTH-1:0] din;
  } port_req_t;

endpackage

// File: rtl/ram_tdp_rdpipe.sv
// Read data / valid pipeline for one RAM port, RD_LAT register stages deep.
module ram_tdp_rdpipe
  import ram_tdp_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] data_q,
  output logic              dvalid
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("ram_tdp_rdpipe: RD_LAT must be 1 or 2");
  end

  if (RD_LAT == 1) begin : g_lat1
    // Single stage: capture on read, hold until the next read.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q <= '0;
        dvalid <= 1'b0;
      end else begin
        dvalid <= rd_en;
        if (rd_en) data_q <= rd_data;
      end
    end
  end else begin : g_lat2
    logic [DWIDTH-1:0] s1_data;
    logic              s1_valid;

    // Two stages: an internal capture stage feeds the held output stage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        data_q   <= '0;
        dvalid   <= 1'b0;
      end else begin
        s1_valid <= rd_en;
        if (rd_en) s1_data <= rd_data;
        dvalid <= s1_valid;
        if (s1_valid) data_q <= s1_data;
      end
    end
  end

endmodule

// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte enables, selectable read latency and a
// same-address write-write collision counter.
module ram_tdp_be
  import ram_tdp_pkg::*;
#(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned RDW_NEW = 0,
  parameter int unsigned CWIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic                  oe_0,
  input  logic [DWIDTH/8-1:0]   be_0,
  input  logic [AWIDTH-1:0]     addr_0,
  input  logic [DWIDTH-1:0]     din_0,
  output logic [DWIDTH-1:0]     dout_0,
  output logic                  dvalid_0,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic                  oe_1,
  input  logic [DWIDTH/8-1:0]   be_1,
  input  logic [AWIDTH-1:0]     addr_1,
  input  logic [DWIDTH-1:0]     din_1,
  output logic [DWIDTH-1:0]     dout_1,
  output logic                  dvalid_1,
  output logic                  coll_pulse,
  output logic [CWIDTH-1:0]     coll_cnt
);

  localparam int unsigned NB    = num_bytes(DWIDTH);
  localparam int unsigned DEPTH = 2 ** AWIDTH;

  if ((DWIDTH % 8) != 0 || DWIDTH == 0 || DWIDTH > MAX_DWIDTH) begin : g_bad_dwidth
    $error("ram_tdp_be: DWIDTH must be a non-zero multiple of 8, at most %0d", MAX_DWIDTH);
  end
  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("ram_tdp_be: RD_LAT must be 1 or 2");
  end
  if (AWIDTH == 0 || AWIDTH > MAX_AWIDTH) begin : g_bad_awidth
    $error("ram_tdp_be: AWIDTH must be in 1..%0d", MAX_AWIDTH);
  end
  if (RDW_NEW != RDW_OLD_DATA && RDW_NEW != RDW_NEW_DATA) begin : g_bad_rdw
    $error("ram_tdp_be: RDW_NEW must be 0 or 1");
  end

  port_req_t         req_0;
  port_req_t         req_1;
  logic              unused_req;

  logic              wr_0;
  logic              wr_1;
  logic              rd_0;
  logic              rd_1;
  logic              same_addr;
  logic              coll;
  logic [AWIDTH-1:0] a_0;
  logic [AWIDTH-1:0] a_1;
  logic [DWIDTH-1:0] d_0;
  logic [DWIDTH-1:0] d_1;
  logic [NB-1:0]     be_w0;
  logic [NB-1:0]     be_w1;
  logic [DWIDTH-1:0] rdata_0;
  logic [DWIDTH-1:0] rdata_1;
  logic [DWIDTH-1:0] data_q_0;
  logic [DWIDTH-1:0] data_q_1;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Bundle each port's pins into a request word.
  always_comb begin
    req_0      = '0;
    req_0.cs   = cs_0;
    req_0.we   = we_0;
    req_0.be   = MAX_BYTES'(be_0);
    req_0.addr = MAX_AWIDTH'(addr_0);
    req_0.din  = MAX_DWIDTH'(din_0);
    req_1      = '0;
    req_1.cs   = cs_1;
    req_1.we   = we_1;
    req_1.be   = MAX_BYTES'(be_1);
    req_1.addr = MAX_AWIDTH'(addr_1);
    req_1.din  = MAX_DWIDTH'(din_1);
  end

  // Padding bits above the configured widths are always zero.
  assign unused_req = ^{req_0, req_1};

  // Decode access type, effective byte masks and same-address collisions.
  always_comb begin
    a_0       = req_0.addr[AWIDTH-1:0];
    a_1       = req_1.addr[AWIDTH-1:0];
    d_0       = req_0.din[DWIDTH-1:0];
    d_1       = req_1.din[DWIDTH-1:0];
    wr_0      = req_0.cs & req_0.we;
    wr_1      = req_1.cs & req_1.we;
    rd_0      = req_0.cs & ~req_0.we;
    rd_1      = req_1.cs & ~req_1.we;
    same_addr = (a_0 == a_1);
    be_w0     = wr_0 ? req_0.be[NB-1:0] : '0;
    be_w1     = wr_1 ? req_1.be[NB-1:0] : '0;
    coll      = same_addr && (|(be_w0 & be_w1));
    // The losing port drops the bytes the winner also writes.
    if (same_addr) begin
      if (COLL_WIN_PORT == 0) be_w1 = be_w1 & ~be_w0;
      else                    be_w0 = be_w0 & ~be_w1;
    end
  end

  // Read word per port, optionally forwarding the other port's write bytes.
  always_comb begin
    rdata_0 = mem[a_0];
    rdata_1 = mem[a_1];
    if (RDW_NEW == RDW_NEW_DATA && same_addr) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be_w1[k]) rdata_0[8*k +: 8] = d_1[8*k +: 8];
        if (be_w0[k]) rdata_1[8*k +: 8] = d_0[8*k +: 8];
      end
    end
  end

  // Byte-masked writes; the masks never overlap on a shared address.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (be_w0[k]) mem[a_0][8*k +: 8] <= d_0[8*k +: 8];
      if (be_w1[k]) mem[a_1][8*k +: 8] <= d_1[8*k +: 8];
    end
  end

  // Collision strobe and saturating collision counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_pulse <= 1'b0;
      coll_cnt   <= '0;
    end else begin
      coll_pulse <= coll;
      if (coll && (coll_cnt != {CWIDTH{1'b1}})) coll_cnt <= coll_cnt + CWIDTH'(1);
    end
  end

  ram_tdp_rdpipe #(
    .DWIDTH (DWIDTH),
    .RD_LAT (RD_LAT)
  ) u_rdpipe_0 (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_0),
    .rd_data (rdata_0),
    .data_q  (data_q_0),
    .dvalid  (dvalid_0)
  );

  ram_tdp_rdpipe #(
    .DWIDTH (DWIDTH),
    .RD_LAT (RD_LAT)
  ) u_rdpipe_1 (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_1),
    .rd_data (rdata_1),
    .data_q  (data_q_1),
    .dvalid  (dvalid_1)
  );

  assign dout_0 = oe_0 ? data_q_0 : '0;
  assign dout_1 = oe_1 ? data_q_1 : '0;

endmodule

// File: tb/tb_ram_tdp_be.sv
// Scoreboard bench for ram_tdp_be: one 8-bit/RD_LAT=1/old-data instance and
// one 16-bit/RD_LAT=2/new-data instance driven by the same stimulus.
module tb_ram_tdp_be;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          cs0 = 1'b0, we0 = 1'b0, oe0 = 1'b1;
  logic          cs1 = 1'b0, we1 = 1'b0, oe1 = 1'b1;
  logic [1:0]    be0 = 2'b00, be1 = 2'b00;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [15:0]   d0 = '0, d1 = '0;

  logic [7:0]  dout_a0, dout_a1, cc_a, cc_b;
  logic [15:0] dout_b0, dout_b1;
  logic        dv_a0, dv_a1, dv_b0, dv_b1, cp_a, cp_b;

  ram_tdp_be #(.AWIDTH(4), .DWIDTH(8), .RD_LAT(1), .RDW_NEW(0), .CWIDTH(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .cs_0(cs0), .we_0(we0), .oe_0(oe0), .be_0(be0[0:0]), .addr_0(a0), .din_0(d0[7:0]),
    .dout_0(dout_a0), .dvalid_0(dv_a0),
    .cs_1(cs1), .we_1(we1), .oe_1(oe1), .be_1(be1[0:0]), .addr_1(a1), .din_1(d1[7:0]),
    .dout_1(dout_a1), .dvalid_1(dv_a1),
    .coll_pulse(cp_a), .coll_cnt(cc_a)
  );

  ram_tdp_be #(.AWIDTH(4), .DWIDTH(16), .RD_LAT(2), .RDW_NEW(1), .CWIDTH(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .cs_0(cs0), .we_0(we0), .oe_0(oe0), .be_0(be0), .addr_0(a0), .din_0(d0),
    .dout_0(dout_b0), .dvalid_0(dv_b0),
    .cs_1(cs1), .we_1(we1), .oe_1(oe1), .be_1(be1), .addr_1(a1), .din_1(d1),
    .dout_1(dout_b1), .dvalid_1(dv_b1),
    .coll_pulse(cp_b), .coll_cnt(cc_b)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_ent_t;

  // Index 2*inst+port for read queues; inst for collision queues.
  rd_ent_t     rq [4][$];
  int          cq [2][$];
  logic [15:0] mem_m [2][16];
  logic [15:0] last_m [4];
  int          cnt_m [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        mon_v;

  logic        dv_all [4];
  logic [15:0] dq_all [4];
  logic        oe_all [4];
  logic        cp_all [2];
  logic [7:0]  cc_all [2];

  always_comb begin
    dv_all[0] = dv_a0;  dv_all[1] = dv_a1;  dv_all[2] = dv_b0;  dv_all[3] = dv_b1;
    dq_all[0] = 16'(dout_a0); dq_all[1] = 16'(dout_a1); dq_all[2] = dout_b0; dq_all[3] = dout_b1;
    oe_all[0] = oe0; oe_all[1] = oe1; oe_all[2] = oe0; oe_all[3] = oe1;
    cp_all[0] = cp_a; cp_all[1] = cp_b;
    cc_all[0] = cc_a; cc_all[1] = cc_b;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Reference model: queue read results / collisions, then update memory.
  task automatic model_step();
    logic [1:0]  bm;
    logic [15:0] msk, rdata;
    logic        wr0, wr1, rd0, rd1, same;
    int          lat;
    bit          rdw;
    for (int j = 0; j < 2; j++) begin
      bm   = (j == 0) ? 2'b01 : 2'b11;
      msk  = (j == 0) ? 16'h00FF : 16'hFFFF;
      lat  = (j == 0) ? 1 : 2;
      rdw  = (j == 1);
      wr0  = cs0 & we0;
      wr1  = cs1 & we1;
      rd0  = cs0 & ~we0;
      rd1  = cs1 & ~we1;
      same = (a0 == a1);
      if (rd0) begin
        rdata = mem_m[j][a0];
        if (rdw && wr1 && same) rdata = merge(rdata, d1, be1 & bm);
        rq[2*j].push_back('{due: cyc + lat, data: rdata & msk});
      end
      if (rd1) begin
        rdata = mem_m[j][a1];
        if (rdw && wr0 && same) rdata = merge(rdata, d0, be0 & bm);
        rq[2*j+1].push_back('{due: cyc + lat, data: rdata & msk});
      end
      if (wr0 && wr1 && same && ((be0 & be1 & bm) != 2'b00)) cq[j].push_back(cyc + 1);
      if (wr1) mem_m[j][a1] = merge(mem_m[j][a1], d1, be1 & bm);
      // Port 0 applied last so it owns bytes both ports write.
      if (wr0) mem_m[j][a0] = merge(mem_m[j][a0], d0, be0 & bm);
    end
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [1:0] e0,
                       input logic [AW-1:0] ad0, input logic [15:0] dd0,
                       input logic c1, input logic w1, input logic [1:0] e1,
                       input logic [AW-1:0] ad1, input logic [15:0] dd1);
    cs0 = c0; we0 = w0; be0 = e0; a0 = ad0; d0 = dd0;
    cs1 = c1; we1 = w1; be1 = e1; a1 = ad1; d1 = dd1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        rq[i].delete();
        last_m[i] = '0;
      end
      for (int j = 0; j < 2; j++) begin
        cq[j].delete();
        cnt_m[j] = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      mon_v = (rq[i].size() > 0) && (rq[i][0].due == cyc);
      check($sformatf("dvalid[%0d]", i), 32'(dv_all[i]), 32'(mon_v));
      if (mon_v) last_m[i] = rq[i].pop_front().data;
      check($sformatf("dout[%0d]", i), 32'(dq_all[i]), 32'(oe_all[i] ? last_m[i] : 16'h0));
    end
    for (int j = 0; j < 2; j++) begin
      mon_v = (cq[j].size() > 0) && (cq[j][0] == cyc);
      if (mon_v) begin
        void'(cq[j].pop_front());
        if (cnt_m[j] < 255) cnt_m[j]++;
      end
      check($sformatf("coll_pulse[%0d]", j), 32'(cp_all[j]), 32'(mon_v));
      check($sformatf("coll_cnt[%0d]", j), 32'(cc_all[j]), 32'(cnt_m[j]));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rb0, rb1;
    logic [3:0]  ra0, ra1;
    logic [15:0] rd0v, rd1v;
    logic        rc0, rw0, rc1, rw1;

    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 16; i++) mem_m[j][i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("rst_dvalid[%0d]", i), 32'(dv_all[i]), 32'h0);
    check("rst_cnt_a", 32'(cc_a), 32'h0);
    check("rst_cnt_b", 32'(cc_b), 32'h0);
    reset = 1'b1;

    // Fill every word with known full-width data
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b1, 2'b11, 4'(i), 16'(16'h0F00 + i * 3), 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);

    // Byte write on port 0, read back on port 1 with and without oe
    drive(1'b1, 1'b1, 2'b01, 4'd3, 16'h00A5, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    idle(3);
    oe1 = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    idle(3);
    oe1 = 1'b1;
    idle(1);

    // Partial-byte update of a full word
    drive(1'b1, 1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b1, 1'b1, 2'b10, 4'd5, 16'hAB00, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b1, 1'b0, 2'b00, 4'd5, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle(3);

    // Same-address write-write collision, then read the winner
    drive(1'b1, 1'b1, 2'b01, 4'd7, 16'h0011, 1'b1, 1'b1, 2'b01, 4'd7, 16'h0022);
    drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle(3);
    // Disjoint byte masks on one address: both land, no collision
    drive(1'b1, 1'b1, 2'b01, 4'd8, 16'h0033, 1'b1, 1'b1, 2'b10, 4'd8, 16'h4400);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 1'b0, 2'b00, 4'd8, 16'h0);
    // Zero byte mask on both ports is a no-op
    drive(1'b1, 1'b1, 2'b00, 4'd9, 16'hFFFF, 1'b1, 1'b1, 2'b00, 4'd9, 16'hEEEE);
    drive(1'b1, 1'b0, 2'b00, 4'd9, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle(3);

    // Cross-port read during write, both directions
    drive(1'b1, 1'b1, 2'b11, 4'd2, 16'h0010, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b1, 1'b1, 2'b11, 4'd2, 16'h0055, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0);
    drive(1'b1, 1'b0, 2'b00, 4'd2, 16'h0, 1'b1, 1'b1, 2'b10, 4'd2, 16'h6600);
    drive(1'b1, 1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle(3);

    // Back-to-back reads of every address while port 0 writes elsewhere
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b1, 2'b11, 4'(15 - i), 16'(16'h7700 + i), 1'b1, 1'b0, 2'b00, 4'(i), 16'h0);
    idle(3);

    // Random traffic on a small address window
    for (int n = 0; n < 200; n++) begin
      rc0 = 1'($urandom_range(0, 1)); rw0 = 1'($urandom_range(0, 1));
      rc1 = 1'($urandom_range(0, 1)); rw1 = 1'($urandom_range(0, 1));
      rb0 = 2'($urandom_range(0, 3)); rb1 = 2'($urandom_range(0, 3));
      ra0 = 4'($urandom_range(0, 3)); ra1 = 4'($urandom_range(0, 3));
      rd0v = 16'($urandom); rd1v = 16'($urandom);
      oe0 = 1'($urandom_range(0, 1)); oe1 = 1'($urandom_range(0, 1));
      drive(rc0, rw0, rb0, ra0, rd0v, rc1, rw1, rb1, ra1, rd1v);
    end
    oe0 = 1'b1;
    oe1 = 1'b1;
    idle(3);

    // Saturate the collision counter
    for (int n = 0; n < 300; n++)
      drive(1'b1, 1'b1, 2'b01, 4'd7, 16'h0011, 1'b1, 1'b1, 2'b01, 4'd7, 16'h0022);
    idle(3);
    check("sat_cnt_a", 32'(cc_a), 32'd255);
    check("sat_cnt_b", 32'(cc_b), 32'd255);

    // Reset with reads in flight
    drive(1'b1, 1'b1, 2'b11, 4'd12, 16'hC3C3, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b1, 1'b0, 2'b00, 4'd3, 16'h0, 1'b1, 1'b0, 2'b00, 4'd12, 16'h0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("inrst_dvalid[%0d]", i), 32'(dv_all[i]), 32'h0);
      check($sformatf("inrst_dout[%0d]", i), 32'(dq_all[i]), 32'h0);
    end
    check("inrst_cnt_a", 32'(cc_a), 32'h0);
    check("inrst_cnt_b", 32'(cc_b), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(5);
    drive(1'b1, 1'b0, 2'b00, 4'd12, 16'h0, 1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    idle(4);

    for (int i = 0; i < 4; i++) check($sformatf("rq_drained[%0d]", i), 32'(rq[i].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
